// File: rtl/menu_navigator.sv
// menu_navigator: arrow-key driven menu with N_FIELDS independent index fields.
// Each field steps up (right) or down (left) and either wraps or saturates.
// Holding an arrow auto-repeats: one step on the press, another after
// HOLD_CYCLES, then one every REPEAT_CYCLES.
//
// Ports:
//   clock, reset (async, active low)
//   right_arrow_pressed, left_arrow_pressed - level arrow inputs
//   load_initial  - clear every field to 0 (beats any step)
//   lock          - suppress all steps
//   menu_sel      - field addressed by arrow steps (>= N_FIELDS selects nothing)
//   values        - packed indices, field 0 in LSBs
//   sel_value / sel_onehot / at_limit - combinational view of the selected field
//   changed       - one-cycle pulse after any index changed

// One menu field: holds its index and computes the next value.
module menu_field #(
    parameter int         IDX_W = 4,
    parameter logic [IDX_W-1:0] MAX = '1,
    parameter bit         WRAP  = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic             dec,
    output logic [IDX_W-1:0] value_n,
    output logic [IDX_W-1:0] value_q
);
    always_comb begin
        value_n = value_q;
        if (load) begin
            value_n = '0;
        end else if (inc) begin
            if (value_q >= MAX) value_n = WRAP ? '0 : MAX;
            else                value_n = value_q + 1'b1;
        end else if (dec) begin
            if (value_q == '0)  value_n = WRAP ? MAX : '0;
            else                value_n = value_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) value_q <= '0;
        else        value_q <= value_n;
    end
endmodule

module menu_navigator #(
    parameter int N_FIELDS = 6,
    parameter int IDX_W    = 4,
    parameter logic [N_FIELDS*IDX_W-1:0] FIELD_MAX = {4'd2, 4'd2, 4'd15, 4'd3, 4'd1, 4'd3},
    parameter logic [N_FIELDS-1:0]       WRAP_MASK = 6'b111111,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250,
    parameter int SEL_W = $clog2(N_FIELDS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      right_arrow_pressed,
    input  logic                      left_arrow_pressed,
    input  logic                      load_initial,
    input  logic                      lock,
    input  logic [SEL_W-1:0]          menu_sel,
    output logic [N_FIELDS*IDX_W-1:0] values,
    output logic [IDX_W-1:0]          sel_value,
    output logic [2**IDX_W-1:0]       sel_onehot,
    output logic                      changed,
    output logic                      at_limit
);
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             dir_q, dir_n;      // 1 = right arrow owns the current hold
    logic             right_q, left_q;
    logic [SEL_W-1:0] sel_q;
    logic             step;
    logic             sel_valid;
    logic             one_arrow;
    logic             abort;

    logic [N_FIELDS-1:0][IDX_W-1:0] field_q, field_n;

    assign sel_valid = ({1'b0, menu_sel} < (SEL_W+1)'(N_FIELDS));
    assign one_arrow = right_arrow_pressed ^ left_arrow_pressed;

    // Any of these drops an in-progress hold back to IDLE in the same cycle.
    assign abort = lock || load_initial || !one_arrow ||
                   (right_arrow_pressed != dir_q) || (menu_sel != sel_q);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        dir_n   = dir_q;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_n = '0;
                if (!lock && !load_initial && one_arrow &&
                    ((right_arrow_pressed && !right_q) || (left_arrow_pressed && !left_q))) begin
                    step    = 1'b1;
                    dir_n   = right_arrow_pressed;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    step    = 1'b1;
                    state_n = REPEAT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            REPEAT: begin
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
                    step  = 1'b1;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            right_q <= 1'b0;
            left_q  <= 1'b0;
            sel_q   <= '0;
            changed <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            dir_q   <= dir_n;
            right_q <= right_arrow_pressed;
            left_q  <= left_arrow_pressed;
            sel_q   <= menu_sel;
            changed <= (field_n != field_q);
        end
    end

    // step is only raised with exactly one arrow high, so the arrow level
    // itself gives the direction.
    for (genvar i = 0; i < N_FIELDS; i++) begin : g_field
        logic hit;
        assign hit = step && sel_valid && (menu_sel == SEL_W'(i));
        menu_field #(
            .IDX_W (IDX_W),
            .MAX   (FIELD_MAX[i*IDX_W +: IDX_W]),
            .WRAP  (WRAP_MASK[i])
        ) u_field (
            .clock   (clock),
            .reset   (reset),
            .load    (load_initial),
            .inc     (hit && right_arrow_pressed),
            .dec     (hit && left_arrow_pressed),
            .value_n (field_n[i]),
            .value_q (field_q[i])
        );
    end

    assign values = field_q;

    logic [IDX_W-1:0] sel_max;
    logic             sel_wrap;

    always_comb begin
        sel_value = '0;
        sel_max   = '0;
        sel_wrap  = 1'b1;
        for (int i = 0; i < N_FIELDS; i++) begin
            if (sel_valid && menu_sel == SEL_W'(i)) begin
                sel_value = field_q[i];
                sel_max   = FIELD_MAX[i*IDX_W +: IDX_W];
                sel_wrap  = WRAP_MASK[i];
            end
        end
    end

    assign sel_onehot = sel_valid ? ((2**IDX_W)'(1) << sel_value) : '0;
    assign at_limit   = sel_valid && !sel_wrap &&
                        ((sel_value == '0) || (sel_value == sel_max));
endmodule

// File: doc/menu_navigator.md
MENU_NAVIGATOR -- requirements
Module: menu_navigator

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- N_FIELDS, 6: number of menu fields.
- IDX_W, 4: bits per field index.
- FIELD_MAX, {4'd2,4'd2,4'd15,4'd3,4'd1,4'd3}: packed highest legal index per field; field 0 sits in the LSBs.
- WRAP_MASK, 6'b111111: bit i=1 means field i wraps; bit i=0 means field i saturates.
- HOLD_CYCLES, 1000: cycles an arrow must be held before auto-repeat starts.
- REPEAT_CYCLES, 250: cycles between auto-repeat steps.
- SEL_W, $clog2(N_FIELDS): derived width of menu_sel.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1: single clock; all state changes on its rising edge.
- reset, in, 1: asynchronous, active-low.
- right_arrow_pressed, in, 1: level input; request to increment.
- left_arrow_pressed, in, 1: level input; request to decrement.
- load_initial, in, 1: load every field to index 0.
- lock, in, 1: block all steps.
- menu_sel, in, SEL_W: field addressed by arrow steps.
- values, out, N_FIELDS*IDX_W: packed binary index of every field.
- sel_value, out, IDX_W: index of the field addressed by menu_sel.
- sel_onehot, out, 2**IDX_W: one-hot decode of sel_value.
- changed, out, 1: one-cycle pulse after any field index changes.
- at_limit, out, 1: selected field is saturating and sits at 0 or at its FIELD_MAX.

Function
REQ-003 Arrow inputs SHALL be sampled into a previous-value register; a press event is the arrow sampled 1 while its previous value was 0.
REQ-004 A step SHALL occur only when exactly one arrow is high. Both arrows high produces no step and forces the repeat FSM to IDLE.
REQ-005 The repeat FSM SHALL have three states:
- IDLE: a press event produces one step and moves to HOLD; the counter clears.
- HOLD: the counter increments each cycle the same arrow stays high. When the counter reaches HOLD_CYCLES-1, it produces one step, moves to REPEAT, and clears the counter.
- REPEAT: when the counter reaches REPEAT_CYCLES-1, it produces one step and clears the counter.
REQ-006 Releasing the arrow, pressing the opposite arrow, changing menu_sel, asserting lock, or asserting load_initial SHALL return the FSM to IDLE with the counter cleared, in the same cycle.
REQ-007 A step SHALL update the addressed field at the same clock edge that samples the triggering condition, so the new index is visible on values and sel_value one cycle after the arrow is first sampled high.
REQ-008 Right SHALL add 1 to the index and left SHALL subtract 1.
- Wrapping field: FIELD_MAX+1 becomes 0, and 0-1 becomes FIELD_MAX.
- Saturating field: the index holds at FIELD_MAX or at 0.
REQ-009 A menu_sel value of N_FIELDS or more SHALL ignore steps. In that case sel_value=0, sel_onehot=0 and at_limit=0.
REQ-010 lock=1 SHALL suppress steps; field indices hold.
REQ-011 load_initial SHALL take priority over any step in the same cycle and set every field to 0.
REQ-012 changed SHALL be registered high for exactly one cycle following an edge where at least one index value differs. A saturated step or a load of already-zero fields SHALL not pulse it.
REQ-013 sel_value, sel_onehot and at_limit SHALL be combinational from the field registers and menu_sel.
REQ-014 Field indices SHALL never exceed their FIELD_MAX.
REQ-015 Counter width SHALL be sized to max(HOLD_CYCLES, REPEAT_CYCLES).

Reset
REQ-016 reset=0 SHALL, asynchronously and at any time including mid-hold, drive:
- all field indices and values to 0;
- changed to 0;
- the FSM to IDLE, with the counter and arrow previous-value registers cleared.
REQ-017 After reset is released, an arrow already held high SHALL count as a press event on the first sampled cycle.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Single step: menu_sel=0, right high for 5 cycles → field0 goes 0→1 one cycle after the first high sample; changed pulses once; no further step.
- Wrap: menu_sel=3, left pulsed once from 0 → field3=15, changed=1. Then right pulsed → field3=0.
- Saturation: WRAP_MASK bit1=0, menu_sel=1, right pulsed 3 times → field1=1, at_limit=1, changed pulsed only on the first press.
- Auto-repeat: HOLD_CYCLES=10, REPEAT_CYCLES=4, menu_sel=3, right held 30 cycles → steps occur on cycles 0, 10, 14, 18, 22 and 26 of the hold; field3=6.
- Conflicts: both arrows high → no change. load_initial together with right press → all fields 0, no step. menu_sel=6 with right press → no change, sel_onehot=0.
- Reset mid-hold: reset=0 during REPEAT → values=0 immediately. Release reset with right still high → one step, field0=1.
